// File: rtl/ram_port_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single RAM port.
// Alternating priority on ties, alignment check and WAIT timeout.
module ram_port_arbiter #(
    parameter int TMO = 15
) (
    input  logic        Clk,
    input  logic        Clr,
    input  logic        IReq,
    input  logic [31:0] IAddr,
    output logic        IDone,
    output logic        IErr,
    output logic [31:0] IData,
    input  logic        DReq,
    input  logic        DRW,
    input  logic [1:0]  DSize,
    input  logic [31:0] DAddr,
    input  logic [31:0] DWData,
    output logic        DDone,
    output logic        DErr,
    output logic [31:0] DRData,
    output logic        MFA,
    output logic        RW,
    output logic [1:0]  Size,
    output logic [31:0] MAddr,
    output logic [31:0] MDOut,
    input  logic [31:0] MDIn,
    input  logic        MOC
);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t      state;
    state_t      nstate;
    logic [3:0]  cnt;
    logic        dsel;
    logic        err_q;
    logic        start;
    logic        pick_d;
    logic        mis;
    logic        tmo_hit;
    logic [31:0] req_addr;
    logic [1:0]  req_size;

    // dsel doubles as the last-grant flag: 0 = fetch, 1 = data
    always_comb begin
        start    = IReq | DReq;
        pick_d   = DReq & (~IReq | ~dsel);
        req_addr = pick_d ? DAddr : IAddr;
        req_size = pick_d ? DSize : 2'b10;
        tmo_hit  = (cnt == 4'(TMO - 1));
        unique case (req_size)
            2'b00:   mis = 1'b0;
            2'b01:   mis = req_addr[0];
            2'b10:   mis = |req_addr[1:0];
            default: mis = 1'b1;
        endcase
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) state <= IDLE;
        else      state <= nstate;
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE: if (start) nstate = mis ? DONE : WAIT;
            WAIT: if (MOC || tmo_hit) nstate = DONE;
            DONE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        MFA   = (state == WAIT);
        IDone = (state == DONE) & ~dsel;
        DDone = (state == DONE) & dsel;
        IErr  = IDone & err_q;
        DErr  = DDone & err_q;
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            cnt    <= '0;
            dsel   <= 1'b0;
            err_q  <= 1'b0;
            MAddr  <= '0;
            RW     <= 1'b0;
            Size   <= '0;
            MDOut  <= '0;
            IData  <= '0;
            DRData <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        dsel  <= pick_d;
                        err_q <= mis;
                        cnt   <= '0;
                        if (!mis) begin
                            MAddr <= req_addr;
                            RW    <= pick_d & DRW;
                            Size  <= req_size;
                            MDOut <= pick_d ? DWData : 32'h0;
                        end
                    end
                end
                WAIT: begin
                    if (MOC) begin
                        if (!RW) begin
                            if (dsel) DRData <= MDIn;
                            else      IData  <= MDIn;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                        if (dsel) DRData <= '0;
                        else      IData  <= '0;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: vector table plus
// hand sequences for ties, back-to-back grants and reset.
module tb_ram_port_arbiter;

    logic        Clk = 1'b0;
    logic        Clr;
    logic        IReq;
    logic [31:0] IAddr;
    logic        IDone;
    logic        IErr;
    logic [31:0] IData;
    logic        DReq;
    logic        DRW;
    logic [1:0]  DSize;
    logic [31:0] DAddr;
    logic [31:0] DWData;
    logic        DDone;
    logic        DErr;
    logic [31:0] DRData;
    logic        MFA;
    logic        RW;
    logic [1:0]  Size;
    logic [31:0] MAddr;
    logic [31:0] MDOut;
    logic [31:0] MDIn;
    logic        MOC;

    int checks = 0;
    int errors = 0;

    ram_port_arbiter #(.TMO(15)) dut (
        .Clk(Clk), .Clr(Clr),
        .IReq(IReq), .IAddr(IAddr), .IDone(IDone),
        .IErr(IErr), .IData(IData),
        .DReq(DReq), .DRW(DRW), .DSize(DSize),
        .DAddr(DAddr), .DWData(DWData), .DDone(DDone),
        .DErr(DErr), .DRData(DRData),
        .MFA(MFA), .RW(RW), .Size(Size), .MAddr(MAddr),
        .MDOut(MDOut), .MDIn(MDIn), .MOC(MOC)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        bit          fetch;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        early;
        logic        drop;
        int          mocw;
        logic [31:0] mdin;
        int          waits;
        int          lat;
        logic        err;
        logic [31:0] rd;
    } vec_t;

    vec_t vt[11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input bit f, input logic rw, input logic [1:0] sz,
        input logic [31:0] a, input logic [31:0] wd,
        input logic early, input logic drop, input int mocw,
        input logic [31:0] mdin, input int waits, input int lat,
        input logic err, input logic [31:0] rd);
        vec_t v;
        v.fetch = f; v.rw = rw; v.size = sz; v.addr = a;
        v.wdata = wd; v.early = early; v.drop = drop;
        v.mocw = mocw; v.mdin = mdin; v.waits = waits;
        v.lat = lat; v.err = err; v.rd = rd;
        return v;
    endfunction

    // Starts from a negedge with the arbiter idle; returns idle too.
    task automatic run_vec(input vec_t v, input string nm);
        int          n;
        int          w;
        bit          seen;
        bit          stab;
        bit          clash;
        logic [1:0]  dn;
        logic        ie;
        logic        de;
        logic [31:0] rdv;
        logic [66:0] exp_bus;
        exp_bus = {v.addr, v.fetch ? 2'b10 : v.size,
                   v.fetch ? 1'b0 : v.rw,
                   v.fetch ? 32'h0 : v.wdata};
        if (v.fetch) begin
            IReq = 1'b1; IAddr = v.addr;
        end else begin
            DReq = 1'b1; DRW = v.rw; DSize = v.size;
            DAddr = v.addr; DWData = v.wdata;
        end
        MOC = v.early;
        MDIn = v.mdin;
        n = 0; w = 0; seen = 0; stab = 1; clash = 0;
        dn = 0; ie = 0; de = 0; rdv = 0;
        while (!seen && n < 40) begin
            @(negedge Clk);
            n++;
            if (MFA) begin
                w++;
                if ({MAddr, Size, RW, MDOut} !== exp_bus) stab = 0;
                if (IDone | DDone) clash = 1;
                IAddr = ~v.addr; DAddr = ~v.addr; DWData = ~v.wdata;
                if (v.drop) begin IReq = 1'b0; DReq = 1'b0; end
                MOC = (w == v.mocw);
            end else begin
                MOC = 1'b0;
            end
            if (IDone | DDone) begin
                seen = 1;
                dn = {IDone, DDone};
                ie = IErr; de = DErr;
                rdv = v.fetch ? IData : DRData;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL %s_timeout: no Done within 40 cycles", nm);
        end
        chk({nm, "_lat"}, 64'(n), 64'(v.lat));
        chk({nm, "_port"}, dn, v.fetch ? 2'b10 : 2'b01);
        chk({nm, "_err"}, {ie, de},
            v.fetch ? {v.err, 1'b0} : {1'b0, v.err});
        chk({nm, "_rdata"}, rdv, v.rd);
        chk({nm, "_waits"}, 64'(w), 64'(v.waits));
        chk({nm, "_stable"}, {stab, clash}, 2'b10);
        IReq = 1'b0; DReq = 1'b0; MOC = 1'b0;
        @(negedge Clk);
        chk({nm, "_pulse"}, {IDone, DDone, MFA}, 3'b000);
    endtask

    initial begin
        bit quiet;
        Clr = 1'b0; IReq = 0; IAddr = 0; DReq = 0; DRW = 0;
        DSize = 0; DAddr = 0; DWData = 0; MDIn = 0; MOC = 0;

        vt[0]  = mk(0, 1, 2'b00, 32'h23, 32'hAB, 0, 0, 1,
                    32'h12345678, 1, 2, 0, 32'hA5A5A5A5);
        vt[1]  = mk(0, 0, 2'b10, 32'h100, 32'h0, 1, 0, 2,
                    32'hDEADBEEF, 2, 3, 0, 32'hDEADBEEF);
        vt[2]  = mk(1, 0, 2'b10, 32'h10, 32'h0, 0, 0, 2,
                    32'hE3A01005, 2, 3, 0, 32'hE3A01005);
        vt[3]  = mk(0, 0, 2'b01, 32'h202, 32'h0, 0, 1, 1,
                    32'h0000BEEF, 1, 2, 0, 32'h0000BEEF);
        vt[4]  = mk(0, 0, 2'b10, 32'h6, 32'h0, 0, 0, 0,
                    32'h0, 0, 1, 1, 32'h0000BEEF);
        vt[5]  = mk(0, 1, 2'b01, 32'h11, 32'h5, 0, 0, 0,
                    32'h0, 0, 1, 1, 32'h0000BEEF);
        vt[6]  = mk(0, 0, 2'b11, 32'h0, 32'h0, 0, 0, 0,
                    32'h0, 0, 1, 1, 32'h0000BEEF);
        vt[7]  = mk(0, 0, 2'b10, 32'h40, 32'h0, 0, 0, 0,
                    32'h77777777, 15, 16, 1, 32'h0);
        vt[8]  = mk(1, 0, 2'b10, 32'h20, 32'h0, 0, 0, 0,
                    32'h66666666, 15, 16, 1, 32'h0);
        vt[9]  = mk(0, 1, 2'b10, 32'h80, 32'hCAFEF00D, 0, 1, 3,
                    32'h44444444, 3, 4, 0, 32'h0);
        vt[10] = mk(0, 0, 2'b00, 32'h3, 32'h0, 0, 0, 1,
                    32'h55, 1, 2, 0, 32'h55);

        repeat (2) @(negedge Clk);
        chk("rst_ram", {MFA, RW, Size, MAddr}, 0);
        chk("rst_mdout", MDOut, 0);
        chk("rst_done", {IDone, IErr, DDone, DErr}, 0);
        chk("rst_data", {IData, DRData}, 0);
        MOC = 1'b1;
        @(negedge Clk);
        chk("rst_moc", {MFA, IDone, DDone}, 0);
        MOC = 1'b0;
        Clr = 1'b1;

        // first tie after reset: data wins, fetch follows without a gap
        IReq = 1; IAddr = 32'h200;
        DReq = 1; DRW = 0; DSize = 2'b10; DAddr = 32'h300;
        @(negedge Clk);
        chk("tie1_dgnt", {MFA, MAddr}, {1'b1, 32'h300});
        MOC = 1; MDIn = 32'hA5A5A5A5;
        @(negedge Clk);
        chk("tie1_ddone", {IDone, DDone, DErr, MFA}, 4'b0100);
        chk("tie1_drd", DRData, 32'hA5A5A5A5);
        DReq = 0; MOC = 0;
        @(negedge Clk);
        chk("tie1_idle", {MFA, IDone, DDone}, 0);
        @(negedge Clk);
        chk("tie1_fgnt", {MFA, MAddr, Size}, {1'b1, 32'h200, 2'b10});
        MOC = 1; MDIn = 32'h11112222;
        @(negedge Clk);
        chk("tie1_fdone", {IDone, IErr, DDone}, 3'b100);
        chk("tie1_ird", IData, 32'h11112222);
        IReq = 0; MOC = 0;
        @(negedge Clk);

        for (int i = 0; i < 11; i++)
            run_vec(vt[i], $sformatf("vec%0d", i));

        // data was granted last, so fetch wins this tie
        IReq = 1; IAddr = 32'h44;
        DReq = 1; DRW = 0; DSize = 2'b10; DAddr = 32'h48;
        @(negedge Clk);
        chk("tie2_fgnt", {MFA, MAddr}, {1'b1, 32'h44});
        MOC = 1; MDIn = 32'h77;
        @(negedge Clk);
        chk("tie2_fdone", {IDone, DDone}, 2'b10);
        chk("tie2_ird", IData, 32'h77);
        IReq = 0; MOC = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk("tie2_dgnt", {MFA, MAddr}, {1'b1, 32'h48});
        MOC = 1; MDIn = 32'h88;
        @(negedge Clk);
        chk("tie2_ddone", {IDone, DDone}, 2'b01);
        chk("tie2_drd", DRData, 32'h88);
        DReq = 0; MOC = 0;
        @(negedge Clk);

        // reset in the middle of WAIT
        DReq = 1; DRW = 0; DSize = 2'b10; DAddr = 32'h100;
        @(negedge Clk);
        chk("mid_wait", MFA, 1);
        #2 Clr = 1'b0;
        #1 chk("mid_async", {MFA, IDone, DDone}, 0);
        chk("mid_regs", {MAddr, IData}, 0);
        DReq = 0;
        @(negedge Clk);
        Clr = 1'b1;
        quiet = 1;
        repeat (3) begin
            @(negedge Clk);
            if (MFA | IDone | DDone) quiet = 0;
        end
        chk("mid_nodone", quiet, 1);
        run_vec(mk(1, 0, 2'b10, 32'h30, 32'h0, 0, 0, 1,
                   32'h99, 1, 2, 0, 32'h99), "mid_fresh");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter TMO, default 15, meaning the maximum number of WAIT cycles without MOC before abort (4-bit counter).
REQ-002 SHALL have port Clk, input, 1, system clock (rising edge).
REQ-003 SHALL have port Clr, input, 1, asynchronous, active-low reset.
REQ-004 SHALL have port IReq, input, 1, instruction-fetch request, held until IDone.
REQ-005 SHALL have port IAddr, input, 32, fetch address (always word).
REQ-006 SHALL have ports IDone (output, 1) and IErr (output, 1), fetch completion pulse and fetch error flag.
REQ-007 SHALL have port IData, output, 32, fetched word, valid while IDone=1.
REQ-008 SHALL have port DReq, input, 1, data request, held until DDone.
REQ-009 SHALL have ports DRW (input, 1; 1=write) and DSize (input, 2; 00 byte, 01 half, 10 word, 11 illegal).
REQ-010 SHALL have ports DAddr (input, 32) and DWData (input, 32), data address and store data.
REQ-011 SHALL have ports DDone (output, 1), DErr (output, 1) and DRData (output, 32), data completion pulse, error flag and load data.
REQ-012 SHALL have ports MFA (output, 1), RW (output, 1), Size (output, 2), MAddr (output, 32) and MDOut (output, 32), the RAM request, direction, size, address and write data.
REQ-013 SHALL have ports MDIn (input, 32) and MOC (input, 1), the RAM read data and memory-operation-complete.

Function
REQ-014 SHALL implement states IDLE, WAIT, DONE.
REQ-015 In IDLE with exactly one Req high, SHALL grant that requester and enter WAIT next cycle.
REQ-016 In IDLE with both Req high, SHALL grant the requester not granted last. The last-grant flag SHALL reset to "fetch", so data wins the first tie.
REQ-017 On grant, SHALL register MAddr, RW, Size and MDOut from the granted port. A fetch SHALL drive RW=0, Size=10 and MDOut=0.
REQ-018 In WAIT, MFA SHALL be 1, and the registered RAM outputs SHALL stay stable.
REQ-019 In WAIT, SHALL sample MOC each rising edge. On MOC=1: on a read, capture MDIn into IData/DRData, then go to DONE.
REQ-020 SHALL count WAIT cycles. If TMO cycles elapse with MOC=0, SHALL go to DONE with the granted port's Err=1 and read data 0.
REQ-021 In DONE, SHALL drive the granted port's Done=1 for exactly one cycle with MFA=0, then return to IDLE.
REQ-022 Minimum latency from Req sampled in IDLE to Done SHALL be 3 cycles (IDLE→WAIT, MOC in first WAIT cycle →DONE).
REQ-023 On misalignment, SHALL skip the RAM access (MFA stays 0) and go IDLE→DONE with Err=1. Misalignment is: word with addr[1:0]≠00, half with addr[0]=1, or DSize=11.
REQ-024 A Req deasserted during WAIT SHALL NOT abort the transaction; Done SHALL still pulse.
REQ-025 The non-granted Req SHALL be ignored until IDLE, and SHALL be served next with no extra cycle.
REQ-026 MOC asserted outside WAIT SHALL be ignored.
REQ-027 Done and Err SHALL be 0 whenever the state is not DONE.
REQ-028 IData/DRData SHALL hold their last captured value outside DONE.

Reset
REQ-029 On Clr=0, SHALL go immediately to IDLE, with MFA, RW, Size, MAddr and MDOut at 0, all Done/Err at 0, IData/DRData at 0, the timeout counter at 0 and last-grant at fetch.
REQ-030 Clr=0 during WAIT SHALL drop MFA asynchronously and SHALL produce no Done for the aborted transaction.

Verification
REQ-031 IReq=1, IAddr=0x00000010, MOC=1 on the 2nd cycle of WAIT with MDIn=0xE3A01005 -> IDone=1 with IData=0xE3A01005, IErr=0, 4 cycles after request.
REQ-032 IReq and DReq rise together after reset -> data served first, fetch granted the cycle after DDone, with no idle gap.
REQ-033 DReq, DRW=1, DSize=00, DAddr=0x00000023, DWData=0x000000AB -> MAddr=0x23, Size=00, RW=1, MDOut=0xAB during WAIT; DDone after MOC.
REQ-034 DSize=10, DAddr=0x00000006 -> MFA never 1, DDone=1 and DErr=1 two cycles after request.
REQ-035 MOC held 0 -> MFA high for 15 cycles, then DDone=1, DErr=1, DRData=0.
REQ-036 Clr pulsed low mid-WAIT -> MFA=0 immediately, no Done, state IDLE; a fresh IReq then completes normally.
